// File: rtl/ai_move_select.sv
// Connect-four style move selector: scans NUM_COLS column scores, returns the best column.
// Optional build macro AI_CENTER_BIAS_EN breaks equal nonzero scores toward the centre column.
module ai_move_select #(
    parameter int NUM_COLS = 7,
    parameter int SCORE_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [2:0]         col_sel,
    input  logic [SCORE_W-1:0] score_in,
    output logic               busy,
    output logic               done,
    output logic [2:0]         best_col,
    output logic [SCORE_W-1:0] best_score,
    output logic               no_move
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    localparam logic [2:0] LAST_COL = 3'(NUM_COLS - 1);

`ifdef AI_CENTER_BIAS_EN
    localparam int CENTER = (NUM_COLS - 1) / 2;

    function automatic int center_dist(input logic [2:0] col);
        return (int'(col) > CENTER) ? int'(col) - CENTER : CENTER - int'(col);
    endfunction
`endif

    state_e             state_q, state_d;
    logic               go_q, go_d;
    logic [2:0]         col_q, col_d;
    logic [SCORE_W-1:0] run_best_q, run_best_d;
    logic [2:0]         run_col_q, run_col_d;
    logic               all_zero_q, all_zero_d;
    logic [2:0]         best_col_q, best_col_d;
    logic [SCORE_W-1:0] best_score_q, best_score_d;
    logic               no_move_q, no_move_d;
    logic               take;

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A start seen in IDLE is captured first; the FSM launches the scan on the following edge.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        state_d = state_q;
        go_d    = (state_q == IDLE) && start && !go_q;
        case (state_q)
            IDLE:    if (go_q) state_d = SCAN;
            SCAN:    if (col_q == LAST_COL) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        take = score_in > run_best_q;
`ifdef AI_CENTER_BIAS_EN
        if (score_in == run_best_q && score_in != '0 &&
            center_dist(col_q) < center_dist(run_col_q))
            take = 1'b1;
`endif
    end

    always_comb begin
        col_d        = col_q;
        run_best_d   = run_best_q;
        run_col_d    = run_col_q;
        all_zero_d   = all_zero_q;
        best_col_d   = best_col_q;
        best_score_d = best_score_q;
        no_move_d    = no_move_q;
        case (state_q)
            IDLE: begin
                if (go_q) begin
                    col_d      = '0;
                    run_best_d = '0;
                    run_col_d  = '0;
                    all_zero_d = 1'b1;
                end
            end
            SCAN: begin
                if (take) begin
                    run_best_d = score_in;
                    run_col_d  = col_q;
                end
                if (score_in != '0) all_zero_d = 1'b0;
                // The last sample is folded in on the same edge the results are published.
                if (col_q == LAST_COL) begin
                    col_d        = '0;
                    best_col_d   = run_col_d;
                    best_score_d = run_best_d;
                    no_move_d    = all_zero_d;
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
            default: col_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go_q         <= 1'b0;
            col_q        <= '0;
            run_best_q   <= '0;
            run_col_q    <= '0;
            all_zero_q   <= 1'b0;
            best_col_q   <= '0;
            best_score_q <= '0;
            no_move_q    <= 1'b0;
        end else begin
            go_q         <= go_d;
            col_q        <= col_d;
            run_best_q   <= run_best_d;
            run_col_q    <= run_col_d;
            all_zero_q   <= all_zero_d;
            best_col_q   <= best_col_d;
            best_score_q <= best_score_d;
            no_move_q    <= no_move_d;
        end
    end

    always_comb begin
        busy       = (state_q == SCAN);
        done       = (state_q == DONE);
        col_sel    = col_q;
        best_col   = best_col_q;
        best_score = best_score_q;
        no_move    = no_move_q;
    end

endmodule
